mdu_seq: RTL and testbench

Parametrised sequential multiply/divide unit, the multi-cycle companion to the combinational datapath ALU in the MIPS pipeline. It executes MULT/MULTU/DIV/DIVU with a radix-2 iterative engine and holds results in architectural HI/LO registers. It also services MTHI/MTLO writes. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/mdu_cneg.sv | 16 +
 rtl/mdu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the sequential multiply/divide unit.
//   - MDU_OP_* : 2-bit operation encodings presented on mdu_seq.op
//   - mdu_state_t : engine state (IDLE, RUN, FIX, DONE)
package mdu_pkg;

   localparam logic [1:0] MDU_OP_MUL  = 2'b00;
   localparam logic [1:0] MDU_OP_DIV  = 2'b01;
   localparam logic [1:0] MDU_OP_MTHI = 2'b10;
   localparam logic [1:0] MDU_OP_MTLO = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_t;

endpackage

// File: rtl/mdu_cneg.sv
// mdu_cneg: conditional two's-complement negator, out_val = neg ? -in_val : in_val.
// Ports:
//   in_val  [W-1:0] value to pass through or negate
//   neg             1 = negate
//   out_val [W-1:0] result
module mdu_cneg #(
   parameter int W = 32
) (
   input  logic [W-1:0] in_val,
   input  logic         neg,
   output logic [W-1:0] out_val
);

   assign out_val = neg ? ({W{1'b0}} - in_val) : in_val;

endmodule

// File: rtl/mdu_seq.sv
// mdu_seq: radix-2 iterative multiply/divide unit with HI/LO registers.
// MUL/DIV run for WIDTH iterations followed by a sign fix-up cycle; MTHI/MTLO
// write HI/LO directly. Divide support is built only when MDU_DIV_EN is defined;
// otherwise a DIV request completes immediately without touching HI/LO.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      operation request (ignored while busy)
//   op [1:0]   00 MUL, 01 DIV, 10 MTHI, 11 MTLO
//   Sign       1 = signed operands
//   A, B       operands (A is also the MTHI/MTLO data)
//   busy       engine occupied
//   done       one-cycle completion pulse
//   div_zero   pulses with done for a DIV with B == 0
//   hi, lo     architectural HI/LO registers
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             Sign,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int W2    = 2 * WIDTH;

   mdu_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Shared accumulator: MUL holds {partial product, multiplier},
   // DIV holds {partial remainder, dividend/quotient}.
   logic [W2-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;    // multiplicand or divisor magnitude
   logic             neg_q, neg_d;        // product/quotient sign
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;

   logic [WIDTH-1:0] a_mag, b_mag;
   logic [W2-1:0]    prod_fix;
   logic [WIDTH:0]   mul_sum;
   logic [W2-1:0]    mul_step;

   mdu_cneg #(.W(WIDTH)) u_mag_a (.in_val(A), .neg(Sign & A[WIDTH-1]), .out_val(a_mag));
   mdu_cneg #(.W(WIDTH)) u_mag_b (.in_val(B), .neg(Sign & B[WIDTH-1]), .out_val(b_mag));
   mdu_cneg #(.W(W2))    u_fix_p (.in_val(prod_q), .neg(neg_q), .out_val(prod_fix));

   // Shift-add: add the multiplicand into the upper half when the current
   // multiplier bit (LSB) is set, then shift the whole accumulator right.
   assign mul_sum  = {1'b0, prod_q[W2-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_step = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
   logic             is_div_q, is_div_d;
   logic             rneg_q, rneg_d;      // remainder sign (dividend sign)
   logic [WIDTH:0]   rem_sh, rem_diff;
   logic [W2-1:0]    div_step;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Restoring step: shift the next dividend bit into the remainder and keep
   // the difference only when it did not borrow; the quotient bit enters at LSB.
   assign rem_sh   = prod_q[W2-1:WIDTH-1];
   assign rem_diff = rem_sh - {1'b0, mcand_q};
   assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};

   mdu_cneg #(.W(WIDTH)) u_fix_q (.in_val(prod_q[WIDTH-1:0]),  .neg(neg_q),  .out_val(quo_fix));
   mdu_cneg #(.W(WIDTH)) u_fix_r (.in_val(prod_q[W2-1:WIDTH]), .neg(rneg_q), .out_val(rem_fix));
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      mcand_d    = mcand_q;
      neg_d      = neg_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = 1'b0;
`ifdef MDU_DIV_EN
      is_div_d   = is_div_q;
      rneg_d     = rneg_q;
`endif
      case (state_q)
         // DONE accepts a new request exactly like IDLE.
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               case (op)
                  MDU_OP_MUL: begin
                     state_d = RUN;
                     cnt_d   = '0;
                     prod_d  = {{WIDTH{1'b0}}, b_mag};
                     mcand_d = a_mag;
                     neg_d   = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef MDU_DIV_EN
                     is_div_d = 1'b0;
`endif
                  end
                  MDU_OP_DIV: begin
`ifdef MDU_DIV_EN
                     if (B == '0) begin
                        state_d    = DONE;
                        hi_d       = A;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                     end else begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        prod_d   = {{WIDTH{1'b0}}, a_mag};
                        mcand_d  = b_mag;
                        neg_d    = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        rneg_d   = Sign & A[WIDTH-1];
                        is_div_d = 1'b1;
                     end
`else
                     state_d = DONE;
`endif
                  end
                  MDU_OP_MTHI: hi_d = A;
                  default:     lo_d = A;
               endcase
            end
         end
         RUN: begin
            cnt_d = cnt_q + CNT_W'(1);
`ifdef MDU_DIV_EN
            prod_d = is_div_q ? div_step : mul_step;
`else
            prod_d = mul_step;
`endif
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end
         default: begin   // FIX
            state_d = DONE;
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[W2-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
`else
            hi_d = prod_fix[W2-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
`endif
         end
      endcase
      // Status outputs are registered copies of the next state.
      busy_d = (state_d == RUN) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         prod_q     <= '0;
         mcand_q    <= '0;
         neg_q      <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q   <= 1'b0;
         rneg_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         mcand_q    <= mcand_d;
         neg_q      <= neg_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
`ifdef MDU_DIV_EN
         is_div_q   <= is_div_d;
         rneg_q     <= rneg_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq (WIDTH=32). Results are predicted
// with plain 64-bit arithmetic; divide scenarios follow the MDU_DIV_EN setting.
module tb_mdu_seq;
   localparam int WIDTH = 32;
   localparam int LAT   = WIDTH + 2;
   localparam logic [1:0] OP_MUL = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             Sign = 1'b0;
   logic [1:0]       op = 2'b00;
   logic [WIDTH-1:0] A = '0, B = '0;
   logic             busy, done, div_zero;
   logic [WIDTH-1:0] hi, lo;

   int               checks = 0;
   int               failures = 0;
   logic [WIDTH-1:0] mdl_hi = '0, mdl_lo = '0;

   mdu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .Sign(Sign),
      .A(A), .B(B), .busy(busy), .done(done), .div_zero(div_zero),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   function automatic logic [2*WIDTH-1:0] mul_model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint pa, pb;
      if (s) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'({{(64-WIDTH){1'b0}}, a});
         pb = longint'({{(64-WIDTH){1'b0}}, b});
      end
      return (2*WIDTH)'(pa * pb);
   endfunction

   task automatic div_model(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
      longint da, db;
      if (s) begin
         da = longint'($signed(a));
         db = longint'($signed(b));
      end else begin
         da = longint'({{(64-WIDTH){1'b0}}, a});
         db = longint'({{(64-WIDTH){1'b0}}, b});
      end
      q = WIDTH'(da / db);
      r = WIDTH'(da % db);
   endtask

   // Called at a negedge; the following posedge samples the request (cycle 0).
   // Returns at the negedge of cycle 1 with the inputs scrambled.
   task automatic pulse_start(input logic [1:0] o, input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      op = o; Sign = s; A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom; Sign = 1'($urandom_range(0, 1)); op = 2'($urandom_range(0, 3));
   endtask

   // Waits (bounded) for done, starting in cycle start_cyc; checks latency,
   // busy during the wait, and the result. Leaves the bench in the done cycle.
   task automatic wait_result(input string name, input int start_cyc, input int exp_lat, input logic exp_busy,
                              input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo, input logic exp_dz);
      int cyc = start_cyc;
      int busy_bad = 0;
      while (done !== 1'b1 && cyc <= 100) begin
         if (busy !== exp_busy) busy_bad++;
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc != exp_lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat); end
      checks++;
      if (busy_bad != 0) begin failures++; $display("FAIL %s busy_wait: %0d cycles with busy != %0b", name, busy_bad, exp_busy); end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
      checks++;
      if (hi !== exp_hi) begin failures++; $display("FAIL %s hi: got %h want %h", name, hi, exp_hi); end
      checks++;
      if (lo !== exp_lo) begin failures++; $display("FAIL %s lo: got %h want %h", name, lo, exp_lo); end
      checks++;
      if (div_zero !== exp_dz) begin failures++; $display("FAIL %s div_zero: got %b want %b", name, div_zero, exp_dz); end
      mdl_hi = exp_hi;
      mdl_lo = exp_lo;
      $display("%s: cyc=%0d hi=%h lo=%h dz=%b", name, cyc, hi, lo, div_zero);
   endtask

   // The cycle after done: pulse gone, results held.
   task automatic check_drop(input string name);
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || div_zero !== 1'b0) begin
         failures++; $display("FAIL %s pulse_width: done=%b div_zero=%b want 0/0", name, done, div_zero);
      end
      checks++;
      if (hi !== mdl_hi || lo !== mdl_lo) begin
         failures++; $display("FAIL %s hold: hi=%h lo=%h want %h %h", name, hi, lo, mdl_hi, mdl_lo);
      end
   endtask

   task automatic mul_one(input string name, input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      p = mul_model(s, a, b);
      @(negedge clk);
      pulse_start(OP_MUL, s, a, b);
      wait_result(name, 1, LAT, 1'b1, p[2*WIDTH-1:WIDTH], p[WIDTH-1:0], 1'b0);
      check_drop(name);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
         failures++; $display("FAIL reset_flags: busy=%b done=%b dz=%b want 000", busy, done, div_zero);
      end
      checks++;
      if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL reset_hilo: hi=%h lo=%h want 0 0", hi, lo); end
      reset = 1'b1;
      mdl_hi = '0;
      mdl_lo = '0;
      $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
   endtask

   task automatic test_mul();
      // Directed cases with hand-derived results.
      @(negedge clk);
      pulse_start(OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_result("mul_neg3x5", 1, LAT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      check_drop("mul_neg3x5");
      @(negedge clk);
      pulse_start(OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("mul_umax", 1, LAT, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      check_drop("mul_umax");
      mul_one("mul_sminxsmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
      for (int i = 0; i < 12; i++) begin
         mul_one($sformatf("mul_rand%0d", i), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
   endtask

`ifdef MDU_DIV_EN
   task automatic div_one(input string name, input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] q, r;
      div_model(s, a, b, q, r);
      @(negedge clk);
      pulse_start(OP_DIV, s, a, b);
      wait_result(name, 1, LAT, 1'b1, r, q, 1'b0);
      check_drop(name);
   endtask
`endif

   task automatic test_div();
`ifdef MDU_DIV_EN
      logic [WIDTH-1:0] a, b;
      logic             s;
      @(negedge clk);
      pulse_start(OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_result("div_neg7_2", 1, LAT, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      check_drop("div_neg7_2");
      @(negedge clk);
      pulse_start(OP_DIV, 1'b0, 32'd7, 32'd2);
      wait_result("div_7_2", 1, LAT, 1'b1, 32'd1, 32'd3, 1'b0);
      check_drop("div_7_2");
      @(negedge clk);
      pulse_start(OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_min_m1", 1, LAT, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
      check_drop("div_min_m1");
      div_one("div_u_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001);
      for (int i = 0; i < 12; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i % 2 == 0) ? WIDTH'($urandom_range(1, 60)) : $urandom;
         if (s && $urandom_range(0, 1) == 1) b = -b;
         if (b == '0) b = 32'd1;
         div_one($sformatf("div_rand%0d", i), s, a, b);
      end
`endif
   endtask

   task automatic test_div_zero();
`ifdef MDU_DIV_EN
      @(negedge clk);
      pulse_start(OP_DIV, 1'($urandom_range(0, 1)), 32'h12, 32'h0);
      wait_result("div_zero", 1, 1, 1'b0, 32'h12, 32'hFFFF_FFFF, 1'b1);
      check_drop("div_zero");
`else
      @(negedge clk);
      pulse_start(OP_DIV, 1'b0, 32'h12, 32'h0);
      wait_result("div_off_b0", 1, 1, 1'b0, mdl_hi, mdl_lo, 1'b0);
      check_drop("div_off_b0");
      @(negedge clk);
      pulse_start(OP_DIV, 1'b1, 32'h1234_5678, 32'd3);
      wait_result("div_off_b3", 1, 1, 1'b0, mdl_hi, mdl_lo, 1'b0);
      check_drop("div_off_b3");
`endif
   endtask

   task automatic test_mthi_mtlo();
      int dones = 0;
      @(negedge clk);
      pulse_start(OP_MTHI, 1'b0, 32'hA5A5_A5A5, 32'h0);
      checks++;
      if (hi !== 32'hA5A5_A5A5 || lo !== mdl_lo) begin
         failures++; $display("FAIL mthi_value: hi=%h lo=%h want %h %h", hi, lo, 32'hA5A5_A5A5, mdl_lo);
      end
      mdl_hi = 32'hA5A5_A5A5;
      @(negedge clk);
      pulse_start(OP_MTLO, 1'b0, 32'h5A5A_0F0F, 32'h0);
      checks++;
      if (lo !== 32'h5A5A_0F0F || hi !== mdl_hi) begin
         failures++; $display("FAIL mtlo_value: hi=%h lo=%h want %h %h", hi, lo, mdl_hi, 32'h5A5A_0F0F);
      end
      mdl_lo = 32'h5A5A_0F0F;
      for (int i = 0; i < 4; i++) begin
         if (done !== 1'b0 || busy !== 1'b0) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin failures++; $display("FAIL mtx_no_done: got %0d busy/done cycles want 0", dones); end
      $display("mthi_mtlo: hi=%h lo=%h", hi, lo);
   endtask

   task automatic test_ignored();
      logic [WIDTH-1:0]   a1, b1;
      logic [2*WIDTH-1:0] p;
      int                 extra = 0;
      a1 = $urandom; b1 = $urandom;
      p = mul_model(1'b0, a1, b1);
      @(negedge clk);
      pulse_start(OP_MUL, 1'b0, a1, b1);              // now cycle 1
      repeat (4) @(negedge clk);                       // cycle 5
      pulse_start(OP_MTLO, 1'b0, 32'hDEAD_BEEF, 32'h0); // cycle 6
      checks++;
      if (lo !== mdl_lo) begin failures++; $display("FAIL ign_mtlo: lo=%h want %h", lo, mdl_lo); end
      repeat (2) @(negedge clk);                       // cycle 8
      pulse_start(OP_MUL, 1'b1, $urandom, $urandom);   // cycle 9
      wait_result("ign_mul", 9, LAT, 1'b1, p[2*WIDTH-1:WIDTH], p[WIDTH-1:0], 1'b0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) extra++;
      end
      checks++;
      if (extra != 0) begin failures++; $display("FAIL ign_queued: got %0d busy/done cycles want 0", extra); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0]   a1, b1, a2, b2;
      logic [2*WIDTH-1:0] p1, p2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      p1 = mul_model(1'b1, a1, b1);
      p2 = mul_model(1'b0, a2, b2);
      @(negedge clk);
      pulse_start(OP_MUL, 1'b1, a1, b1);
      wait_result("b2b_first", 1, LAT, 1'b1, p1[2*WIDTH-1:WIDTH], p1[WIDTH-1:0], 1'b0);
      pulse_start(OP_MUL, 1'b0, a2, b2);               // sampled in the DONE cycle
      wait_result("b2b_second", 1, LAT, 1'b1, p2[2*WIDTH-1:WIDTH], p2[WIDTH-1:0], 1'b0);
      check_drop("b2b_second");
   endtask

   task automatic test_reset_mid();
      int spurious = 0;
      @(negedge clk);
      pulse_start(OP_MTHI, 1'b0, 32'h1111_2222, 32'h0);
      pulse_start(OP_MTLO, 1'b0, 32'h3333_4444, 32'h0);
      pulse_start(OP_MUL, 1'b0, $urandom | 32'h1, $urandom | 32'h1); // cycle 1
      repeat (9) @(negedge clk);                                     // cycle 10
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
         failures++; $display("FAIL rstmid_flags: busy=%b done=%b dz=%b want 000", busy, done, div_zero);
      end
      checks++;
      if (hi !== '0 || lo !== '0) begin failures++; $display("FAIL rstmid_hilo: hi=%h lo=%h want 0 0", hi, lo); end
      mdl_hi = '0;
      mdl_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) spurious++;
      end
      checks++;
      if (spurious != 0) begin failures++; $display("FAIL rstmid_after: got %0d disturbed cycles want 0", spurious); end
      $display("reset_mid: spurious=%0d", spurious);
      mul_one("rstmid_next", 1'b1, $urandom, $urandom);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_mthi_mtlo();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
